// File: rtl/csa_tree_pipelined_adder.sv
// Pipelined multi-operand adder built from 3:2 carry-save levels.
// Each CSA level is followed by a register stage. A registered
// carry-lookahead adder then sums the last two rows. Latency is L+1 cycles,
// throughput is one operand set per cycle, and stalls are global.
//
// Ports:
//   clk, rst_n          clock; asynchronous active-low reset
//   flush               synchronous kill of all in-flight transactions
//   in_valid/in_ready   input handshake (in_ready = !stall)
//   in_signed           1: operands are two's complement, 0: unsigned
//   in_tag              opaque tag returned with the result
//   in_ops              NUM_OPS operands of N bits
//   out_valid/out_ready output handshake
//   out_sum             sum modulo 2^OUT_W
//   out_tag             tag of the result
//   busy                any stage holds a valid transaction
module csa_tree_pipelined_adder #(
  parameter int unsigned NUM_OPS = 9,
  parameter int unsigned N       = 32,
  parameter int unsigned OUT_W   = N + $clog2(NUM_OPS),
  parameter int unsigned TAG_W   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_signed,
  input  logic [TAG_W-1:0]              in_tag,
  input  logic [NUM_OPS-1:0][N-1:0]     in_ops,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OUT_W-1:0]              out_sum,
  output logic [TAG_W-1:0]              out_tag,
  output logic                          busy
);

  // Row count after lvl CSA levels (lvl = 0 is the operand set itself).
  function automatic int unsigned rows_at(input int unsigned lvl);
    int unsigned m;
    m = NUM_OPS;
    for (int unsigned i = 0; i < lvl; i++) m = m - m / 3;
    return m;
  endfunction

  function automatic int unsigned num_levels();
    int unsigned m;
    int unsigned l;
    m = NUM_OPS;
    l = 0;
    while (m > 2) begin
      m = m - m / 3;
      l++;
    end
    return l;
  endfunction

  // Row offset of level lvl (1-based) inside the flat registered row vector.
  function automatic int unsigned reg_off(input int unsigned lvl);
    int unsigned o;
    o = 0;
    for (int unsigned i = 1; i < lvl; i++) o = o + rows_at(i);
    return o;
  endfunction

  localparam int unsigned L   = num_levels();
  localparam int unsigned TOT = reg_off(L + 1);
  localparam int unsigned FB  = reg_off(L);

  logic [NUM_OPS*OUT_W-1:0]         ext;
  logic [TOT*OUT_W-1:0]             rows_d, rows_q;
  logic [(NUM_OPS+TOT)*OUT_W-1:0]   all_rows;
  logic [OUT_W-1:0]                 sum_d, sum_q;
  logic [L:0]                       vld_q;
  logic [L:0][TAG_W-1:0]            tag_q;
  logic                             stall;

  assign stall     = vld_q[L] & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = vld_q[L];
  assign out_sum   = sum_q;
  assign out_tag   = tag_q[L];
  assign busy      = |vld_q;

  always_comb begin
    ext = '0;
    for (int unsigned i = 0; i < NUM_OPS; i++) begin
      if (in_signed) ext[i*OUT_W +: OUT_W] = OUT_W'($signed(in_ops[i]));
      else           ext[i*OUT_W +: OUT_W] = OUT_W'(in_ops[i]);
    end
  end

  // Operand rows occupy the bottom of the vector; registered level k rows follow.
  assign all_rows = {rows_q, ext};

  always_comb begin : p_csa
    int unsigned      ib, ob, mi;
    logic [OUT_W-1:0] a, b, c;
    ib     = 0;
    ob     = 0;
    mi     = 0;
    a      = '0;
    b      = '0;
    c      = '0;
    rows_d = '0;
    for (int unsigned k = 1; k <= L; k++) begin
      ib = (k == 1) ? 0 : NUM_OPS + reg_off(k - 1);
      ob = reg_off(k);
      mi = rows_at(k - 1);
      for (int unsigned g = 0; g < mi / 3; g++) begin
        a = all_rows[(ib + 3*g)     * OUT_W +: OUT_W];
        b = all_rows[(ib + 3*g + 1) * OUT_W +: OUT_W];
        c = all_rows[(ib + 3*g + 2) * OUT_W +: OUT_W];
        rows_d[(ob + 2*g)     * OUT_W +: OUT_W] = a ^ b ^ c;
        rows_d[(ob + 2*g + 1) * OUT_W +: OUT_W] = ((a & b) | (a & c) | (b & c)) << 1;
      end
      // Leftover rows that did not fill a triple pass through unchanged.
      for (int unsigned r = 0; r < mi % 3; r++) begin
        rows_d[(ob + 2*(mi/3) + r) * OUT_W +: OUT_W] =
          all_rows[(ib + 3*(mi/3) + r) * OUT_W +: OUT_W];
      end
    end
  end

  // Final add: parallel-prefix (Kogge-Stone) carry lookahead, carry-in 0.
  always_comb begin : p_cla
    logic [OUT_W-1:0] x, y, p, gn, pn;
    x  = rows_q[FB * OUT_W +: OUT_W];
    y  = rows_q[(FB + 1) * OUT_W +: OUT_W];
    p  = x ^ y;
    gn = x & y;
    pn = p;
    for (int unsigned d = 1; d < OUT_W; d = d << 1) begin
      gn = gn | (pn & (gn << d));
      pn = pn & (pn << d);
    end
    sum_d = p ^ (gn << 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      tag_q  <= '0;
      rows_q <= '0;
      sum_q  <= '0;
    end else begin
      // Flush beats stall; bubbles advance like any other slot.
      if (flush)       vld_q <= '0;
      else if (!stall) vld_q <= {vld_q[L-1:0], in_valid};
      if (!stall) begin
        tag_q  <= {tag_q[L-1:0], in_tag};
        rows_q <= rows_d;
        sum_q  <= sum_d;
      end
    end
  end

endmodule
